spi_reg_ctrl: RTL and testbench

- SPI-slave command controller that sequences register reads and writes from the external MCU onto the internal register bus: VIDC shadow registers at 0x000, video output regs at 0x8xx, clock control at 0xCxx.
- Deserialises 48-bit SPI frames, issues one req/ack bus transaction per frame, and serialises read data back in the same frame.
- Sits between the top-level spi_* pins and the register-bus decoder.

---
 rtl/spi_reg_ctrl_if.sv | 20 ++
 rtl/spi_reg_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: internal register-bus bundle (req/ack handshake).
// master drives req/wr/addr/wdata; slave returns rdata with a one-cycle ack.
interface spi_reg_ctrl_if;
  logic        req;
  logic        wr;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, wr, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI slave, 48-bit frames -> one register-bus access each.
// Ports: clk, nreset, spi_clk/ncs/din in, spi_dout, err_timeout, bus (master).
// Define SPI_REG_CTRL_STATUS_EN to make cmd 10 a status read.
module spi_reg_ctrl #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          ACK_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFFFFFF
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           spi_clk,
  input  logic           spi_ncs,
  input  logic           spi_din,
  output logic           spi_dout,
  output logic           err_timeout,
  spi_reg_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, HDR, RD_REQ, DATA, WR_REQ, DONE
  } state_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  state_t st, nxt;

  logic [SYNC_STAGES-1:0] sclk_sy, ncs_sy, din_sy;
  logic        sclk, ncs, din;
  logic        sclk_q, ncs_q;
  logic        rise, ncs_fall;
  logic [5:0]  cnt;
  logic        edge16, edge48;
  logic [31:0] sh_in, sh_out;
  logic [1:0]  cmd_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [TW-1:0] tmr;
  logic        err_q;
  logic        req_on, tmo;
  logic [31:0] hdr_load;

  assign sclk = sclk_sy[SYNC_STAGES-1];
  assign ncs  = ncs_sy[SYNC_STAGES-1];
  assign din  = din_sy[SYNC_STAGES-1];

  // ncs chain resets to 1 so reset release never looks like a frame start
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      sclk_sy <= '0;
      ncs_sy  <= '1;
      din_sy  <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi_clk};
      ncs_sy  <= {ncs_sy[SYNC_STAGES-2:0], spi_ncs};
      din_sy  <= {din_sy[SYNC_STAGES-2:0], spi_din};
      sclk_q  <= sclk;
      ncs_q   <= ncs;
    end

  assign rise     = sclk & ~sclk_q & ~ncs;
  assign ncs_fall = ~ncs & ncs_q;
  assign edge16   = rise && (cnt == 6'd15);
  assign edge48   = rise && (cnt == 6'd47);

  always_ff @(posedge clk or negedge nreset)
    if (!nreset)               cnt <= '0;
    else if (ncs || ncs_fall)  cnt <= '0;
    else if (rise)             cnt <= cnt + 6'd1;

  assign req_on = (st == RD_REQ) || (st == WR_REQ);
  assign tmo    = req_on && !bus.ack && (tmr == TMAX);

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) st <= IDLE;
    else         st <= nxt;

  // on the 16th edge sh_in[14:13] is cmd, [12:1] addr, [0] and din pad
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:   if (!ncs) nxt = HDR;
      HDR:
        if (ncs)
          nxt = IDLE;
        else if (edge16)
          nxt = (sh_in[14:13] == 2'b00) ? RD_REQ : DATA;
      RD_REQ: if (bus.ack || tmo) nxt = ncs ? DONE : DATA;
      DATA:
        if (ncs)
          nxt = IDLE;
        else if (edge48)
          nxt = (cmd_q == 2'b01) ? WR_REQ : DONE;
      WR_REQ: if (bus.ack || tmo) nxt = DONE;
      DONE:   if (ncs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.req     = req_on;
  assign bus.wr      = (st == WR_REQ);
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign spi_dout    = (st == DATA) & sh_out[31];
  assign err_timeout = err_q;

`ifdef SPI_REG_CTRL_STATUS_EN
  logic [7:0] frm_cnt, tmo_cnt;

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      frm_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (st == DATA && edge48 && frm_cnt != 8'hFF)
        frm_cnt <= frm_cnt + 8'd1;
      if (tmo && tmo_cnt != 8'hFF)
        tmo_cnt <= tmo_cnt + 8'd1;
    end

  assign hdr_load = (sh_in[14:13] == 2'b10) ?
                    {16'h0, frm_cnt, tmo_cnt} : '0;
`else
  assign hdr_load = '0;
`endif

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      sh_in   <= '0;
      sh_out  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmr     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rise) sh_in <= {sh_in[30:0], din};
      tmr <= req_on ? tmr + TW'(1) : '0;
      if (st == HDR && edge16) begin
        cmd_q  <= sh_in[14:13];
        addr_q <= sh_in[12:1];
        sh_out <= hdr_load;
      end
      if (st == RD_REQ) begin
        if (bus.ack)  sh_out <= bus.rdata;
        else if (tmo) sh_out <= TIMEOUT_RDATA;
      end
      if (st == DATA && rise)
        sh_out <= {sh_out[30:0], 1'b0};
      if (st == DATA && edge48)
        wdata_q <= {sh_in[30:0], din};
      if (tmo)
        err_q <= 1'b1;
      else if (st == IDLE && !ncs)
        err_q <= 1'b0;
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed SPI frames against spi_reg_ctrl
// with a bus responder that records each request.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic nreset;
  logic spi_clk, spi_ncs, spi_din;
  logic spi_dout, err_timeout;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl dut (
    .clk         (clk),
    .nreset      (nreset),
    .spi_clk     (spi_clk),
    .spi_ncs     (spi_ncs),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .err_timeout (err_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int hp     = 8;

  int          ack_dly;
  logic [31:0] rd_val;
  int          n_req, n_unstable, hi, last_hi;
  logic        req_q;
  logic        cap_wr;
  logic [11:0] cap_addr;
  logic [31:0] cap_wdata;
  int          frames_done, tmo_seen;
  logic [47:0] rx;
  logic [31:0] exp_st;

  initial begin
    bus.ack   = 1'b0;
    bus.rdata = '0;
    req_q     = 1'b0;
    hi        = 0;
    last_hi   = 0;
  end

  always @(negedge clk) begin
    if (bus.req === 1'b1) begin
      if (!req_q) begin
        n_req++;
        cap_wr    = bus.wr;
        cap_addr  = bus.addr;
        cap_wdata = bus.wdata;
        hi        = 0;
      end else if (bus.wr !== cap_wr || bus.addr !== cap_addr ||
                   bus.wdata !== cap_wdata) begin
        n_unstable++;
      end
      hi++;
      if (ack_dly > 0 && hi == ack_dly) begin
        bus.ack   = 1'b1;
        bus.rdata = rd_val;
      end else begin
        bus.ack = 1'b0;
      end
    end else begin
      if (req_q) last_hi = hi;
      bus.ack = 1'b0;
    end
    req_q = (bus.req === 1'b1);
  end

  function automatic logic [47:0] mk(input logic [1:0] c,
                                     input logic [11:0] a,
                                     input logic [31:0] d);
    return {c, a, 2'b00, d};
  endfunction

  task automatic clr_mon;
    n_req      = 0;
    n_unstable = 0;
    last_hi    = 0;
  endtask

  task automatic spi_frame(input logic [47:0] tx, input int n,
                           input int gap, input bit hold,
                           output logic [47:0] r);
    r = '0;
    spi_ncs = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 47; i >= 48 - n; i--) begin
      spi_din = tx[i];
      repeat (hp) @(negedge clk);
      spi_clk = 1'b1;
      r[i] = spi_dout;
      repeat (hp) @(negedge clk);
      spi_clk = 1'b0;
      if (i == 32) repeat (gap) @(negedge clk);
    end
    if (!hold) begin
      repeat (hp) @(negedge clk);
      spi_ncs = 1'b1;
      repeat (4 * hp) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    nreset  = 1'b0;
    spi_ncs = 1'b1;
    spi_clk = 1'b0;
    spi_din = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req !== 1'b0) begin
      fails++; $display("FAIL rst_req: got %b want 0", bus.req);
    end
    checks++;
    if (bus.wr !== 1'b0) begin
      fails++; $display("FAIL rst_wr: got %b want 0", bus.wr);
    end
    checks++;
    if (bus.addr !== 12'h0) begin
      fails++; $display("FAIL rst_addr: got %h want 000", bus.addr);
    end
    checks++;
    if (bus.wdata !== 32'h0) begin
      fails++; $display("FAIL rst_wdata: got %h want 0", bus.wdata);
    end
    checks++;
    if (spi_dout !== 1'b0) begin
      fails++; $display("FAIL rst_dout: got %b want 0", spi_dout);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      fails++; $display("FAIL rst_err: got %b want 0", err_timeout);
    end
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.req !== 1'b0) begin
      fails++; $display("FAIL idle_req: got %b want 0", bus.req);
    end
  endtask

  task automatic test_nreset_mid;
    clr_mon();
    ack_dly = 0;
    spi_frame(mk(2'b00, 12'h3A5, 32'h0), 16, 0, 1, rx);
    repeat (10) @(negedge clk);
    checks++;
    if (bus.req !== 1'b1) begin
      fails++; $display("FAIL mid_req_up: got %b want 1", bus.req);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0) begin
      fails++; $display("FAIL mid_rst_req: got %b want 0", bus.req);
    end
    checks++;
    if (spi_dout !== 1'b0) begin
      fails++; $display("FAIL mid_rst_dout: got %b want 0", spi_dout);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      fails++; $display("FAIL mid_rst_err: got %b want 0", err_timeout);
    end
    spi_ncs = 1'b1;
    spi_din = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    frames_done = 0;
    tmo_seen    = 0;
    clr_mon();
    ack_dly = 2;
    rd_val  = 32'h1234ABCD;
    spi_frame(mk(2'b00, 12'h3A5, 32'h0), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (n_req != 1 || cap_wr !== 1'b0 || cap_addr !== 12'h3A5) begin
      fails++;
      $display("FAIL post_rst_req: got n=%0d wr=%b a=%h want 1 0 3a5",
               n_req, cap_wr, cap_addr);
    end
    checks++;
    if (rx !== 48'h0000_1234ABCD) begin
      fails++; $display("FAIL post_rst_rx: got %h want 00001234abcd", rx);
    end
  endtask

  task automatic test_noop_status;
    clr_mon();
    spi_frame(mk(2'b11, 12'hC01, 32'hFFFFFFFF), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (rx !== 48'h0) begin
      fails++; $display("FAIL noop_rx: got %h want 0", rx);
    end
    checks++;
    if (n_req != 0) begin
      fails++; $display("FAIL noop_req: got %0d want 0", n_req);
    end
`ifdef SPI_REG_CTRL_STATUS_EN
    exp_st = {16'h0, frames_done[7:0], tmo_seen[7:0]};
`else
    exp_st = 32'h0;
`endif
    clr_mon();
    spi_frame(mk(2'b10, 12'h000, 32'h0), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (rx !== {16'h0, exp_st}) begin
      fails++; $display("FAIL status_rx: got %h want %h", rx, exp_st);
    end
    checks++;
    if (n_req != 0) begin
      fails++; $display("FAIL status_req: got %0d want 0", n_req);
    end
  endtask

  task automatic test_write;
    clr_mon();
    ack_dly = 1;
    spi_frame(mk(2'b01, 12'h808, 32'h00000001), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (n_req != 1) begin
      fails++; $display("FAIL wr_nreq: got %0d want 1", n_req);
    end
    checks++;
    if (cap_wr !== 1'b1 || cap_addr !== 12'h808) begin
      fails++;
      $display("FAIL wr_cmd: got wr=%b a=%h want 1 808", cap_wr, cap_addr);
    end
    checks++;
    if (cap_wdata !== 32'h00000001) begin
      fails++; $display("FAIL wr_data: got %h want 00000001", cap_wdata);
    end
    checks++;
    if (last_hi != 1) begin
      fails++; $display("FAIL wr_req_len: got %0d want 1", last_hi);
    end
    checks++;
    if (err_timeout !== 1'b0 || n_unstable != 0) begin
      fails++;
      $display("FAIL wr_err: got err=%b unstable=%0d want 0 0",
               err_timeout, n_unstable);
    end
  endtask

  task automatic test_read;
    clr_mon();
    ack_dly = 3;
    rd_val  = 32'h005A5A5A;
    spi_frame(mk(2'b00, 12'h014, 32'h0), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (n_req != 1 || cap_wr !== 1'b0 || cap_addr !== 12'h014) begin
      fails++;
      $display("FAIL rd_req: got n=%0d wr=%b a=%h want 1 0 014",
               n_req, cap_wr, cap_addr);
    end
    checks++;
    if (rx[31:0] !== 32'h005A5A5A) begin
      fails++; $display("FAIL rd_data: got %h want 005a5a5a", rx[31:0]);
    end
    checks++;
    if (rx[47:32] !== 16'h0) begin
      fails++; $display("FAIL rd_hdr: got %h want 0", rx[47:32]);
    end
    checks++;
    if (last_hi != 3) begin
      fails++; $display("FAIL rd_req_len: got %0d want 3", last_hi);
    end
  endtask

  task automatic test_abort;
    clr_mon();
    ack_dly = 1;
    spi_frame(mk(2'b01, 12'h808, 32'hDEADBEEF), 30, 0, 0, rx);
    checks++;
    if (n_req != 0) begin
      fails++; $display("FAIL abort_req: got %0d want 0", n_req);
    end
    clr_mon();
    spi_frame(mk(2'b01, 12'h015, 32'h00CACE00), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (n_req != 1 || cap_wr !== 1'b1 || cap_addr !== 12'h015) begin
      fails++;
      $display("FAIL abort_next: got n=%0d wr=%b a=%h want 1 1 015",
               n_req, cap_wr, cap_addr);
    end
    checks++;
    if (cap_wdata !== 32'h00CACE00) begin
      fails++; $display("FAIL abort_wdata: got %h want 00cace00", cap_wdata);
    end
  endtask

  task automatic test_timeout;
    clr_mon();
    ack_dly = 0;
    spi_frame(mk(2'b00, 12'h000, 32'h0), 48, 300, 0, rx);
    frames_done++;
    tmo_seen++;
    checks++;
    if (n_req != 1 || last_hi != 255) begin
      fails++;
      $display("FAIL tmo_req: got n=%0d len=%0d want 1 255", n_req, last_hi);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      fails++; $display("FAIL tmo_err: got %b want 1", err_timeout);
    end
    checks++;
    if (rx[31:0] !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL tmo_rdata: got %h want ffffffff", rx[31:0]);
    end
    clr_mon();
    spi_frame(mk(2'b11, 12'hC01, 32'h0), 48, 0, 0, rx);
    frames_done++;
    checks++;
    if (err_timeout !== 1'b0) begin
      fails++; $display("FAIL tmo_clear: got %b want 0", err_timeout);
    end
  endtask

  initial begin
    ack_dly = 0;
    rd_val  = '0;
    frames_done = 0;
    tmo_seen    = 0;
    clr_mon();
    test_reset();
    test_nreset_mid();
    test_noop_status();
    test_write();
    test_read();
    test_abort();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish within 5ms");
    $fatal(1, "watchdog expired");
  end
endmodule
